// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave arbiter for the CPU's Avalon-style memory bus.
// Master 0 is instruction fetch, master 1 is load/store. One transaction is
// in flight at a time; the winner's request is latched and held on the
// slave port until accepted, and completion is signalled by a single
// low cycle on the winner's waitrequest.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin arbitration instead
// of fixed m1 priority).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate and latch a new request
// ST_ISSUE | strobe on slave port, waiting for s_waitrequest low
// ST_RDATA | read accepted; capture s_readdata at the next edge
// ST_DONE  | owner's waitrequest low for one cycle, then back to idle

module mips_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    input  logic [DW/8-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DW-1:0]     m0_readdata,
    input  logic [AW-1:0]     m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    input  logic [DW/8-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DW-1:0]     m1_readdata,
    output logic [AW-1:0]     s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DW-1:0]     s_writedata,
    output logic [DW/8-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DW-1:0]     s_readdata,
    output logic              owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RDATA = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     s_address_q, s_address_d;
    logic [DW-1:0]     s_writedata_q, s_writedata_d;
    logic [DW/8-1:0]   s_byteenable_q, s_byteenable_d;
    logic              s_read_q, s_read_d;
    logic              s_write_q, s_write_d;
    logic              owner_q, owner_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic              req0, req1;
    logic              grant;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_q names the master preferred on a tie (the one not served last)
    logic              rr_q, rr_d;

    // Pointer moves to the other master as a transaction enters DONE
    always_comb begin
        rr_d = rr_q;
        if ((state_q == ST_ISSUE && !s_waitrequest && s_write_q) ||
            state_q == ST_RDATA) begin
            rr_d = ~owner_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Tie goes to the pointer; a lone requester always wins
    always_comb begin
        grant = (req0 && req1) ? rr_q : req1;
    end
`else
    // Fixed priority: m1 wins whenever it requests
    always_comb begin
        grant = req1;
    end
`endif

    // Next-state and datapath latch logic
    always_comb begin
        state_d        = state_q;
        s_address_d    = s_address_q;
        s_writedata_d  = s_writedata_q;
        s_byteenable_d = s_byteenable_q;
        s_read_d       = s_read_q;
        s_write_d      = s_write_q;
        owner_d        = owner_q;
        rdata_d        = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_ISSUE;
                    owner_d = grant;
                    if (grant) begin
                        s_address_d    = m1_address;
                        s_writedata_d  = m1_writedata;
                        s_byteenable_d = m1_byteenable;
                        s_write_d      = m1_write;
                        s_read_d       = m1_read & ~m1_write;
                    end else begin
                        s_address_d    = m0_address;
                        s_writedata_d  = m0_writedata;
                        s_byteenable_d = m0_byteenable;
                        s_write_d      = m0_write;
                        s_read_d       = m0_read & ~m0_write;
                    end
                end
            end
            ST_ISSUE: begin
                if (!s_waitrequest) begin
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    state_d   = s_write_q ? ST_DONE : ST_RDATA;
                end
            end
            ST_RDATA: begin
                rdata_d = s_readdata;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            s_address_q    <= '0;
            s_writedata_q  <= '0;
            s_byteenable_q <= '0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            owner_q        <= 1'b0;
            rdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            s_address_q    <= s_address_d;
            s_writedata_q  <= s_writedata_d;
            s_byteenable_q <= s_byteenable_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            owner_q        <= owner_d;
            rdata_q        <= rdata_d;
        end
    end

    assign s_address      = s_address_q;
    assign s_writedata    = s_writedata_q;
    assign s_byteenable   = s_byteenable_q;
    assign s_read         = s_read_q;
    assign s_write        = s_write_q;
    assign owner          = owner_q;
    assign m0_waitrequest = !(state_q == ST_DONE && owner_q == 1'b0);
    assign m1_waitrequest = !(state_q == ST_DONE && owner_q == 1'b1);
    assign m0_readdata    = (owner_q == 1'b0) ? rdata_q : '0;
    assign m1_readdata    = (owner_q == 1'b1) ? rdata_q : '0;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter. A transaction-level model
// (busy / accepted / age-since-acceptance) predicts every output each cycle;
// directed scenarios add literal latency, ordering and data expectations.
// Build with ARB_ROUND_ROBIN_EN defined to check the round-robin variant.

module tb_mips_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic [31:0] s_address;
    logic        s_read, s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        owner;

    int checks = 0;
    int errors = 0;

    mips_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          mdl_busy, mdl_acc, mdl_wr, mdl_owner, mdl_ptr;
    int          mdl_age;
    logic [31:0] mdl_addr, mdl_wdata, mdl_rdata;
    logic [3:0]  mdl_be;

    always @(posedge clk) begin
        bit r0, r1, w;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (reset) begin
            mdl_busy = 0; mdl_acc = 0; mdl_wr = 0; mdl_owner = 0; mdl_ptr = 0;
            mdl_age = 0; mdl_addr = 0; mdl_wdata = 0; mdl_rdata = 0; mdl_be = 0;
        end else if (!mdl_busy) begin
            if (r0 || r1) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = (r0 && r1) ? mdl_ptr : r1;
`else
                w = r1;
`endif
                mdl_busy  = 1;
                mdl_acc   = 0;
                mdl_owner = w;
                mdl_addr  = w ? m1_address : m0_address;
                mdl_wdata = w ? m1_writedata : m0_writedata;
                mdl_be    = w ? m1_byteenable : m0_byteenable;
                mdl_wr    = w ? m1_write : m0_write;
            end
        end else if (!mdl_acc) begin
            if (!s_waitrequest) begin
                mdl_acc = 1;
                mdl_age = 1;
            end
        end else if (!mdl_wr && mdl_age == 1) begin
            mdl_rdata = s_readdata;
            mdl_age   = 2;
        end else begin
            mdl_busy = 0;
            mdl_acc  = 0;
            mdl_ptr  = !mdl_owner;
        end
    end

    // Compare every output against the model, away from the active edge
    always @(negedge clk) begin
        bit done;
        done = mdl_busy && mdl_acc && (mdl_age == (mdl_wr ? 1 : 2));
        chk("s_read",         32'(s_read),  32'(mdl_busy && !mdl_acc && !mdl_wr));
        chk("s_write",        32'(s_write), 32'(mdl_busy && !mdl_acc && mdl_wr));
        chk("s_address",      s_address,    mdl_addr);
        chk("s_writedata",    s_writedata,  mdl_wdata);
        chk("s_byteenable",   32'(s_byteenable), 32'(mdl_be));
        chk("owner",          32'(owner),   32'(mdl_owner));
        chk("m0_waitrequest", 32'(m0_waitrequest), 32'(!(done && !mdl_owner)));
        chk("m1_waitrequest", 32'(m1_waitrequest), 32'(!(done && mdl_owner)));
        chk("m0_readdata",    m0_readdata, mdl_owner ? 32'h0 : mdl_rdata);
        chk("m1_readdata",    m1_readdata, mdl_owner ? mdl_rdata : 32'h0);
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic drive(input bit m, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        if (m) begin
            m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = data; m1_byteenable = be;
        end else begin
            m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = data; m0_byteenable = be;
        end
    endtask

    // Called just after a negedge while the arbiter is idle; returns at the
    // negedge of the completion cycle with the request already dropped.
    task automatic run_one(input bit m, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be, input int stall,
                           output int lat, output int strobes, output bit saw_read);
        bit done;
        drive(m, rd, wr, addr, data, be);
        s_waitrequest = (stall > 0);
        lat = 0; strobes = 0; saw_read = 0; done = 0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (s_read || s_write) begin
                strobes++;
                chk("strobe_address", s_address, addr);
                if (wr) chk("strobe_writedata", s_writedata, data);
                s_waitrequest = (strobes <= stall);
            end
            if (s_read) saw_read = 1;
            if ((m ? m1_waitrequest : m0_waitrequest) == 1'b0) begin
                lat  = c;
                done = 1;
                drive(m, 0, 0, addr, data, be);
            end
        end
        if (!done) chk("txn_timeout", 32'd0, 32'd1);
        s_waitrequest = 1'b0;
    endtask

    task automatic pair(output int first, output int second);
        int n;
        n = 0; first = -1; second = -1;
        drive(0, 1, 0, 32'h0000_1000, 32'h0, 4'hF);
        drive(1, 1, 0, 32'h0000_2000, 32'h0, 4'hF);
        for (int c = 0; c < 40 && n < 2; c++) begin
            @(negedge clk);
            if (!m0_waitrequest) begin
                if (n == 0) first = 0; else second = 0;
                n++;
                drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
            end
            if (!m1_waitrequest) begin
                if (n == 0) first = 1; else second = 1;
                n++;
                drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
            end
        end
        if (n < 2) chk("pair_timeout", 32'(n), 32'd2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, strobes, f, s;
        bit saw_read;
        reset = 1'b1;
        s_waitrequest = 1'b0;
        s_readdata = 32'h0;
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_s_read", 32'(s_read), 32'd0);
            chk("idle_s_write", 32'(s_write), 32'd0);
            chk("idle_m0_wait", 32'(m0_waitrequest), 32'd1);
            chk("idle_m1_wait", 32'(m1_waitrequest), 32'd1);
            chk("idle_owner", 32'(owner), 32'd0);
        end

        // m0 read, zero stall
        s_readdata = 32'h3C08_BFC0;
        run_one(0, 1, 0, 32'hBFC0_0000, 32'h0, 4'hF, 0, lat, strobes, saw_read);
        chk("m0_read_latency", 32'(lat), 32'd3);
        chk("m0_read_strobes", 32'(strobes), 32'd1);
        chk("m0_readdata_val", m0_readdata, 32'h3C08_BFC0);
        chk("m1_readdata_zero", m1_readdata, 32'h0);
        @(negedge clk);

        // m1 write with four stall cycles
        run_one(1, 0, 1, 32'hBFC0_0030, 32'hBFC0_0018, 4'hF, 4, lat, strobes, saw_read);
        chk("m1_write_latency", 32'(lat), 32'd6);
        chk("m1_write_strobes", 32'(strobes), 32'd5);
        chk("m1_write_dropped", 32'(s_write), 32'd0);
        chk("m1_write_m0_wait", 32'(m0_waitrequest), 32'd1);
        @(negedge clk);

        // read and write together: write wins
        run_one(1, 1, 1, 32'hBFC0_002C, 32'hDEAD_BEEF, 4'h3, 0, lat, strobes, saw_read);
        chk("rw_no_read", 32'(saw_read), 32'd0);
        chk("rw_latency", 32'(lat), 32'd2);
        chk("rw_strobes", 32'(strobes), 32'd1);
        @(negedge clk);

        // simultaneous reads, starting from reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        s_readdata = 32'h1234_5678;
        pair(f, s);
`ifdef ARB_ROUND_ROBIN_EN
        chk("pair1_first", 32'(f), 32'd0);
        chk("pair1_second", 32'(s), 32'd1);
`else
        chk("pair1_first", 32'(f), 32'd1);
        chk("pair1_second", 32'(s), 32'd0);
`endif
        @(negedge clk);
        pair(f, s);
`ifdef ARB_ROUND_ROBIN_EN
        chk("pair2_first", 32'(f), 32'd0);
        chk("pair2_second", 32'(s), 32'd1);
`else
        chk("pair2_first", 32'(f), 32'd1);
        chk("pair2_second", 32'(s), 32'd0);
`endif
        @(negedge clk);

        // reset while stalled in issue
        s_waitrequest = 1'b1;
        drive(0, 1, 0, 32'hBFC0_0100, 32'h0, 4'hF);
        @(negedge clk);
        chk("pre_reset_s_read", 32'(s_read), 32'd1);
        reset = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        s_waitrequest = 1'b0;
        chk("rst_s_read", 32'(s_read), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_s_address", s_address, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
            chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        end
        s_readdata = 32'hCAFE_F00D;
        run_one(0, 1, 0, 32'hBFC0_0200, 32'h0, 4'hF, 0, lat, strobes, saw_read);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_rdata", m0_readdata, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Two-master, one-slave arbiter for the CPU's Avalon-style memory bus (address/read/write/waitrequest/writedata/byteenable/readdata).
- Master 0 is the instruction-fetch port; master 1 is the load/store data port.
- The single slave is the test memory or the system interconnect.
- Serialises transactions, latches the winning request, and drives it to the slave until it is accepted.
- Returns read data and completion to the winning master via its own waitrequest.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits; byteenable width is DW/8

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
m0_address  in  AW  fetch master byte address
m0_read  in  1  fetch master read request
m0_write  in  1  fetch master write request
m0_writedata  in  DW  fetch master write data
m0_byteenable  in  DW/8  fetch master byte enables
m0_waitrequest  out  1  low for exactly one cycle when m0's transaction completes
m0_readdata  out  DW  read data, valid while m0_waitrequest low after a read
m1_*  same set as m0_*, for the data master
s_address  out  AW  slave address
s_read  out  1  slave read strobe
s_write  out  1  slave write strobe
s_writedata  out  DW  slave write data
s_byteenable  out  DW/8  slave byte enables
s_waitrequest  in  1  slave stall; request accepted at an edge where it is low
s_readdata  in  DW  slave read data, valid the cycle after read acceptance
owner  out  1  master currently owning the bus (debug)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset (edge with reset=1):
  - state=IDLE; s_read=s_write=0.
  - s_address, s_writedata, s_byteenable, captured readdata all 0.
  - owner=0; RR pointer=0.
  - Both mN_waitrequest=1.
  - Applies mid-transaction too: the pending transfer is abandoned, and its master never sees waitrequest low.
- mN_waitrequest = 0 only when state==DONE and owner==N; 1 in every other state, including IDLE.
- mN_readdata = captured register when owner==N, otherwise 0.
- Request of master N: mN_read|mN_write.
  - If both strobes are high, write wins and read is ignored.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise select a winner (arbitration below), then on the edge:
    - latch address, writedata, byteenable and the op into the s_* registers;
    - set s_read or s_write; set owner; go to ISSUE.
- ISSUE:
  - s_* held stable.
  - Edge with s_waitrequest=1: stay in ISSUE.
  - Edge with s_waitrequest=0: clear s_read/s_write. Write goes to DONE; read goes to RDATA.
- RDATA: capture s_readdata on the edge; go to DONE.
- DONE:
  - One cycle with the owner's waitrequest=0 (and readdata valid for a read).
  - Go to IDLE.
  - The master must deassert or change its request during DONE; the arbiter does not sample requests in DONE.
- Minimum latency from IDLE request to waitrequest low, with zero slave stall: write 2 cycles, read 3 cycles.
- No back-to-back issue: one IDLE cycle between transactions.
- Arbitration, default (fixed priority): m1 beats m0 when both request in the same IDLE cycle.
- A request arriving while the other master is in ISSUE/RDATA/DONE waits, with waitrequest held high.
- Width rules: addresses and data pass through unmodified; no alignment checks or address translation.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin pointer; when both request, the master not served last wins.
  - Pointer updates on entry to DONE; after reset m0 is preferred first.
  - A single requester always wins regardless of pointer.
- Undefined: pointer logic absent; fixed m1 priority as above.

Test Plan:
- Reset 2 cycles, then idle 5 cycles -> s_read=s_write=0, m0/m1_waitrequest=1, owner=0 throughout.
- m0 read 0xBFC00000, slave returns 0x3C08BFC0 with s_waitrequest=0 -> s_read high 1 cycle with s_address=0xBFC00000; m0_waitrequest low exactly 3 cycles after request, m0_readdata=0x3C08BFC0.
- m1 write 0xBFC00030 data 0xBFC00018, byteenable 4'b1111, slave waitrequest high 4 cycles -> s_write held with stable address/data for 5 cycles; m1_waitrequest low once, 6 cycles after request; s_write drops after acceptance.
- m0 read and m1 read asserted in the same cycle:
  - Without the macro: m1 served first, then m0.
  - With ARB_ROUND_ROBIN_EN: m0 first after reset; repeated simultaneous pair alternates m1, m0, m1.
- Reset asserted while in ISSUE with s_waitrequest=1 -> next edge s_read=0, state IDLE, neither master's waitrequest goes low; a new m0 read afterwards completes normally.
- m1 asserts read and write together, address 0xBFC0002C -> only s_write asserted, s_read stays 0.
